// File: rtl/seq_mem_adapter_pkg.sv
// Shared types for the sequential-memory request adapter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Contents: adapter FSM state encoding, the response flag bundle that sits
// beside the data word in each response FIFO entry, and a pointer-width helper.
package seq_mem_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Data width is a module parameter, so the full response struct is built
    // in the top level as {data, rsp_flags_t}; the flag layout lives here so
    // every user agrees on bit order.
    typedef struct packed {
        logic write;
        logic err;
    } rsp_flags_t;

    localparam int RSP_FLAGS_W = $bits(rsp_flags_t);

    // A one-entry FIFO still needs a 1-bit pointer to keep the vectors legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/seq_mem_rsp_fifo.sv
// Synchronous response FIFO, DEPTH entries of DW bits, head shown combinationally.
// Latency: a push is visible at the head the cycle after the pushing edge.
// Backpressure: caller must only push with a free slot; pop is ignored when empty.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset (pointers/count only)
//   i_push         write i_push_dat at the tail this cycle
//   i_pop          drop the head this cycle (no effect when empty)
//   o_count        number of stored entries, 0..DEPTH
//   o_head         entry at the head (undefined when o_empty)
//   o_empty        no entries stored
module seq_mem_rsp_fifo
    import seq_mem_adapter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 34,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_dat,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output logic [DW-1:0] o_head,
    output logic          o_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LP_LAST = PW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;

    // Explicit wrap so non-power-of-two depths would also be safe.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LP_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; consumers gate the head with o_empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/seq_mem_req_adapter_d1.sv
// Serializes valid/ready requests onto a single-port sequential memory, one in flight.
// Latency: accept T -> strobe T+1 -> done sampled T+2 -> rsp_valid T+3 (range error: rsp_valid T+2).
// Backpressure: req_ready only in IDLE with a free response slot; rsp_* held until rsp_ready.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_write, req_addr, req_wdata  request op, word address, write data
//   rsp_valid/rsp_ready             response handshake (FIFO head)
//   rsp_data, rsp_write, rsp_err    read data (0 for writes/errors), op echo, error
//   mem_addr0, mem_in               memory address / write data (hold last in-range request)
//   mem_read_en, mem_write_en       one-cycle strobes, never together
//   mem_out, mem_read_done, mem_write_done   memory read data and completion flags
module seq_mem_req_adapter_d1
    import seq_mem_adapter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 8,
    parameter int IDX_SIZE  = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [IDX_SIZE-1:0] req_addr,
    input  logic [WIDTH-1:0]    req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                rsp_write,
    output logic                rsp_err,
    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic [WIDTH-1:0]    mem_in,
    input  logic [WIDTH-1:0]    mem_out,
    input  logic                mem_read_done,
    input  logic                mem_write_done
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        rsp_flags_t       flags;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0]     LP_DEPTH = CW'(RSP_DEPTH);
    // One extra bit so SIZE == 2**IDX_SIZE still compares correctly.
    localparam logic [IDX_SIZE:0] LP_SIZE  = (IDX_SIZE + 1)'(SIZE);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_write;
    logic [IDX_SIZE-1:0]   r_mem_addr;
    logic [WIDTH-1:0]      r_mem_in;
    logic                  r_mem_read_en;
    logic                  r_mem_write_en;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_done;
    logic                  w_push;
    rsp_t                  w_push_dat;
    logic                  w_pop;
    logic [CW-1:0]         w_count;
    logic [RSP_W-1:0]      w_head;
    rsp_t                  w_head_rsp;
    logic                  w_empty;

    // Ready is a function of state and FIFO occupancy only. Requiring a free
    // slot at accept time means the later push can never overflow.
    assign w_req_ready = (r_state == IDLE) && (w_count < LP_DEPTH);
    assign w_accept    = req_valid && w_req_ready;
    assign w_in_range  = ({1'b0, req_addr} < LP_SIZE);
    assign w_done      = r_write ? mem_write_done : mem_read_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_push_dat   = '0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_in_range ? ISSUE : ERR;
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                // A missing done turns into an error response with zero data.
                w_push                 = 1'b1;
                w_push_dat.data        = (!r_write && w_done) ? mem_out : '0;
                w_push_dat.flags.write = r_write;
                w_push_dat.flags.err   = !w_done;
                w_next_state           = IDLE;
            end
            ERR: begin
                w_push                 = 1'b1;
                w_push_dat.flags.write = r_write;
                w_push_dat.flags.err   = 1'b1;
                w_next_state           = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request latch. Address and write data only update for in-range requests
    // so the memory pins never carry an out-of-range address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_in   <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            if (w_in_range) begin
                r_mem_addr <= req_addr;
                r_mem_in   <= req_wdata;
            end
        end
    end

    // Strobes are registered off the next state, so they are high exactly
    // while the FSM sits in ISSUE. ISSUE is only entered from an IDLE accept,
    // hence the op comes straight from req_write. Reset clears them, so a
    // request interrupted in ISSUE/WAIT is never re-strobed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
        end else begin
            r_mem_read_en  <= (w_next_state == ISSUE) && !req_write;
            r_mem_write_en <= (w_next_state == ISSUE) &&  req_write;
        end
    end

    seq_mem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (RSP_W)
    ) u_rsp_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_count    (w_count),
        .o_head     (w_head),
        .o_empty    (w_empty)
    );

    assign w_pop      = rsp_valid && rsp_ready;
    assign w_head_rsp = w_head;

    assign req_ready    = w_req_ready;
    assign rsp_valid    = !w_empty;
    // Head storage is unreset; force zeros while nothing is presented.
    assign rsp_data     = w_empty ? '0   : w_head_rsp.data;
    assign rsp_write    = w_empty ? 1'b0 : w_head_rsp.flags.write;
    assign rsp_err      = w_empty ? 1'b0 : w_head_rsp.flags.err;
    assign mem_addr0    = r_mem_addr;
    assign mem_in       = r_mem_in;
    assign mem_read_en  = r_mem_read_en;
    assign mem_write_en = r_mem_write_en;

endmodule
